// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a valid/ready handshake,
// synchronous flush (bubble insertion) and an optional two-entry skid buffer.
//
// Parameters:
//   DATA_W        payload width in bits (opaque, never inspected)
//   SKID          1: main + skid register, in_ready_o is a flop output
//                 0: single register, in_ready_o = !out_valid_o || out_ready_i
//   ZERO_ON_FLUSH 1: flush clears the payload registers; 0: only the valids clear
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset (priority over flush)
//   flush_i      drop every held entry and the input offered this cycle
//   in_valid_i   upstream payload valid
//   in_ready_o   block accepts a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  head payload valid
//   out_ready_i  downstream consumes the head this cycle
//   out_data_o   head payload
//   count_o      occupancy (0..2 with SKID=1, 0..1 with SKID=0)
module pipe_stage_reg #(
  parameter int unsigned DATA_W        = 64,
  parameter bit          SKID          = 1'b1,
  parameter bit          ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = main_q;
  assign count_o     = count_q;

  // With SKID the ready is purely registered, so out_ready_i never reaches in_ready_o
  // combinationally. The rst gate holds ready low during reset; rst is a local
  // synchronous control, not part of the stall chain.
  assign in_ready_o = ~rst & (SKID ? in_ready_q : (~out_valid_o | out_ready_i));

  // An input offered during flush is discarded even though in_ready_o may read 1.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    count_d    = count_q;
    in_ready_d = in_ready_q;

    if (SKID) begin
      case (count_q)
        2'd0: begin
          if (push) begin
            main_d  = in_data_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            main_d = in_data_i;
          end else if (push) begin
            // Late stall: ready was still high, park the extra payload behind the head.
            skid_d  = in_data_i;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // in_ready_o is low here, so only a pop can happen.
          if (pop) begin
            main_d  = skid_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
      in_ready_d = (count_d != 2'd2);
    end else begin
      if (push) begin
        main_d  = in_data_i;
        count_d = 2'd1;
      end else if (pop) begin
        count_d = 2'd0;
      end
      in_ready_d = 1'b1;
    end

    if (flush_i) begin
      count_d    = 2'd0;
      in_ready_d = 1'b1;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      count_q    <= 2'd0;
      // Ready comes up the first cycle after reset; held low meanwhile by the rst gate.
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register that replaces the per-stage hand-written stall/zero registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque packed payload of DATA_W bits between two stages with a valid/ready handshake, synchronous flush (bubble insertion) and an optional two-entry skid buffer. The skid buffer makes in_ready a pure flop output, which breaks the combinational stall path through the core. Stages pack their control/data fields into in_data and unpack from out_data.

## Interface
Parameters:
- DATA_W, 64: payload width in bits (≥1); the ID/EX instance packs pc, inst, operands, imm and control fields.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_ON_FLUSH, 1: 1 = payload registers are cleared to 0 on flush; 0 = payload registers keep stale data and only the valids clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard every held entry and the input offered this cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head payload is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  DATA_W  head payload.
- count  out  2  occupancy: 0..2 with SKID=1, 0..1 with SKID=0.

## Operation
- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready. Both are evaluated at the same edge.
- Storage: a main register (head, drives out_data) plus a skid register (SKID=1 only). FIFO order is always preserved.
- SKID=1 state machine, encoded by count:
  - EMPTY (0): push -> ONE, main <= in_data.
  - ONE (1), push and pop -> ONE, main <= in_data.
  - ONE, push only -> FULL, skid <= in_data.
  - ONE, pop only -> EMPTY.
  - FULL (2), pop -> ONE, main <= skid. A push cannot occur in FULL because in_ready=0.
- SKID=1 signal definitions:
  - in_ready is registered and equals (next count != 2).
  - out_valid = (count != 0).
- SKID=0 signal definitions:
  - in_ready = !out_valid || out_ready (combinational).
  - A push loads main. A pop with no push clears out_valid.
- Flush has priority over push and pop:
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - An input offered in the flush cycle is dropped. in_ready may still read 1 during the flush cycle, but no transfer is recorded.
  - With ZERO_ON_FLUSH=1, main and skid are cleared to 0.
- rst has priority over flush:
  - main, skid, out_data = 0; count = 0; out_valid = 0.
  - in_ready is forced to 0 while rst is high, and is 1 in the first cycle after rst falls.
- Payload is never inspected, so no width rules apply beyond DATA_W passthrough.
- Handshake rules:
  - Upstream must hold in_data stable while in_valid && !in_ready.
  - The block holds out_data and out_valid stable while out_valid && !out_ready, except on flush or rst.
  - A pop with out_valid=0 has no effect.

## Timing
- Latency: a payload accepted at edge N appears on out_valid/out_data after edge N (1 cycle). The skid path adds no latency to the head.
- Throughput: 1 payload/cycle sustained when out_ready is held at 1, in both modes.
- SKID=1 stall timing:
  - out_ready falling reaches in_ready one cycle later.
  - The one payload accepted in that window lands in skid (FULL); nothing is lost.
- SKID=1 release timing: when out_ready rises in FULL, in_ready returns to 1 at the next edge.
- SKID=1 path constraint: no combinational path from out_ready to in_ready.
- SKID=0 path: out_ready -> in_ready is combinational.
- flush or rst asserted mid-stall takes effect at that edge. There is no partial state.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 and in_data=0xAA -> out_valid=0, out_data=0, count=0 and in_ready=0 throughout; in_ready=1 on the first cycle after release.
- Streaming, SKID=1: push 0x1..0x8 on consecutive cycles with out_ready=1 -> out_data=0x1..0x8, each one cycle after its push, no gaps, count stays 1.
- Backpressure, SKID=1:
  - Push 0x10, 0x11, 0x12 while out_ready=0 -> count reaches 2; in_ready=0 after the 2nd push; 0x12 is held upstream.
  - Raise out_ready -> output order 0x10, 0x11, 0x12 with no drop or duplicate.
- Flush while FULL:
  - Occupancy is 0x20/0x21; assert flush with in_valid=1 and in_data=0x22 -> next cycle count=0, out_valid=0, out_data=0 (ZERO_ON_FLUSH=1); 0x22 is never output.
  - Rerun with ZERO_ON_FLUSH=0 -> out_valid=0 and out_data is still 0x20.
- SKID=0 bubble insertion:
  - Push 0x30, then hold out_ready=0 -> in_ready=0 in the same cycle.
  - Then pop and push 0x31 in the same cycle -> out_data=0x31 next cycle, count=1.
- Simultaneous push and pop in ONE (SKID=1): head 0x40, push 0x41 while popping -> next cycle out_data=0x41, count=1, skid unused.
